spi_frame_slave: RTL and testbench



---
 rtl/spi_frame_slave_pkg.sv | 10 +
 rtl/sync_edge.sv | 33 +++
 rtl/spi_frame_slave.sv | 135 +++++++++++++
 tb/tb_spi_frame_slave.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_slave_pkg.sv
// Shared constants for the SPI mode-0 frame slave: byte width and FSM state encoding.
package spi_frame_slave_pkg;

  localparam int SPI_BYTE_BITS = 8;

  localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with one-clk rise/fall pulses
// taken between the synchronised value and a one-cycle-delayed copy of it.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic nreset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // NOTE: every flop in a clocked block uses <= so the chain shifts by exactly one stage per edge.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync_out = chain[STAGES-1];
  assign rise     = chain[STAGES-1] & ~prev;
  assign fall     = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave front end: pin synchronisation, MSB-first byte deserialise/serialise,
// frame start/end strobes and byte index. The MISO pin is named miso because do is a reserved word.
module spi_frame_slave
  import spi_frame_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     sclk,
  input  logic                     di,
  input  logic                     ncs,
  output logic                     miso,
  output logic [SPI_BYTE_BITS-1:0] rx_data,
  output logic                     rx_valid,
  input  logic [SPI_BYTE_BITS-1:0] tx_data,
  output logic                     tx_taken,
  output logic                     frame_start,
  output logic                     frame_end,
  output logic [IDX_W-1:0]         byte_index,
  output logic                     busy
);

  localparam int BIT_W    = $clog2(SPI_BYTE_BITS);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [BIT_W-1:0]    LAST_BIT   = BIT_W'(SPI_BYTE_BITS - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ncs_sync, ncs_rise, ncs_fall;
  logic di_sync;
  logic [1:0] di_edge_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .nreset(nreset), .async_in(sclk),
    .sync_out(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
    .clk(clk), .nreset(nreset), .async_in(ncs),
    .sync_out(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_di_sync (
    .clk(clk), .nreset(nreset), .async_in(di),
    .sync_out(di_sync), .rise(di_edge_unused[0]), .fall(di_edge_unused[1])
  );

  logic [1:0]               state;
  logic [SETTLE_W-1:0]      settle_cnt;
  logic                     settled;
  logic [BIT_W-1:0]         bit_cnt;
  logic [SPI_BYTE_BITS-1:0] rx_shift;
  logic [SPI_BYTE_BITS-1:0] tx_shift;
  logic                     unused_sclk_level;

  // The ncs chain resets to "deselected"; until the pin value has propagated through
  // it, a high ncs_sync is stale and must not be trusted to leave WAIT_IDLE.
  assign settled           = (settle_cnt == SETTLE_MAX);
  assign busy              = (state == ST_SHIFT);
  assign unused_sclk_level = sclk_sync;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= ST_WAIT_IDLE;
      settle_cnt  <= '0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_taken    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      byte_index  <= '0;
      miso        <= 1'b1;
    end else begin
      // NOTE: strobes default low at the top so each branch only states when they pulse.
      rx_valid    <= 1'b0;
      tx_taken    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      if (!settled) settle_cnt <= settle_cnt + SETTLE_W'(1);

      case (state)
        ST_WAIT_IDLE: begin
          miso <= 1'b1;
          if (settled && ncs_sync) state <= ST_IDLE;
        end

        ST_IDLE: begin
          miso <= 1'b1;
          if (ncs_fall) begin
            frame_start <= 1'b1;
            tx_taken    <= 1'b1;
            tx_shift    <= tx_data;
            miso        <= tx_data[SPI_BYTE_BITS-1];
            bit_cnt     <= '0;
            byte_index  <= '1;
            state       <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_shift <= {rx_shift[SPI_BYTE_BITS-2:0], di_sync};
            bit_cnt  <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              rx_data    <= {rx_shift[SPI_BYTE_BITS-2:0], di_sync};
              rx_valid   <= 1'b1;
              byte_index <= byte_index + IDX_W'(1);
              tx_shift   <= tx_data;
              tx_taken   <= 1'b1;
              miso       <= tx_data[SPI_BYTE_BITS-1];
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            // A fall right after a byte boundary keeps the freshly loaded MSB on the line.
            tx_shift <= tx_shift << 1;
            miso     <= tx_shift[SPI_BYTE_BITS-2];
          end

          if (ncs_rise) begin
            frame_end <= 1'b1;
            miso      <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: SPI master model driving pins, table of single-byte frames,
// hand-written multi-byte, abort, reset and coincident-end sequences, rx scoreboard queue.
module tb_spi_frame_slave;

  localparam int SYNC_STAGES = 2;
  localparam int IDX_W       = 8;
  localparam int H           = 4;   // sclk half period in clk cycles (clk = 8 x sclk)

  logic             clk = 1'b0;
  logic             nreset;
  logic             sclk, di, ncs;
  logic             miso;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_data;
  logic             tx_taken;
  logic             frame_start, frame_end;
  logic [IDX_W-1:0] byte_index;
  logic             busy;

  spi_frame_slave #(.SYNC_STAGES(SYNC_STAGES), .IDX_W(IDX_W)) dut (
    .clk(clk), .nreset(nreset), .sclk(sclk), .di(di), .ncs(ncs),
    .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_taken(tx_taken),
    .frame_start(frame_start), .frame_end(frame_end),
    .byte_index(byte_index), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       data;
    logic [IDX_W-1:0] idx;
  } rx_exp_t;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  rx_exp_t    rx_q[$];
  logic [7:0] tx_step_q[$];
  bit         tx_step_en = 1'b0;

  int cnt_fs = 0, cnt_fe = 0, cnt_tt = 0, cnt_rv = 0, cnt_coinc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling clk edge, scores rx bytes and counts strobes.
  always @(negedge clk) begin
    if (frame_start) cnt_fs++;
    if (frame_end)   cnt_fe++;
    if (rx_valid && tx_taken && frame_end) cnt_coinc++;
    if (tx_taken) begin
      cnt_tt++;
      if (tx_step_en && tx_step_q.size() > 0) tx_data = tx_step_q.pop_front();
    end
    if (rx_valid) begin
      cnt_rv++;
      if (rx_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_unexpected: got byte 0x%0h idx %0d, expected none", rx_data, byte_index);
      end else begin
        rx_exp_t e;
        e = rx_q.pop_front();
        check("rx_data", rx_data, e.data);
        check("byte_index", byte_index, e.idx);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic frame_begin();
    ncs = 1'b0;
    clks(8);
  endtask

  task automatic frame_stop();
    clks(H);
    ncs = 1'b1;
    clks(8);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      di = b[i];
      clks(H);
      got[i] = miso;
      sclk = 1'b1;
      clks(H);
      sclk = 1'b0;
    end
  endtask

  task automatic expect_rx(input logic [7:0] d, input logic [IDX_W-1:0] idx);
    rx_exp_t e;
    e.data = d;
    e.idx  = idx;
    rx_q.push_back(e);
  endtask

  initial begin
    vec_t       vecs[4];
    logic [7:0] got;
    int fs0, fe0, tt0, rv0, cc0;

    vecs[0] = '{mosi: 8'hA5, tx: 8'h3C, exp_rx: 8'hA5, exp_miso: 8'h3C};
    vecs[1] = '{mosi: 8'h00, tx: 8'hFF, exp_rx: 8'h00, exp_miso: 8'hFF};
    vecs[2] = '{mosi: 8'hFF, tx: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
    vecs[3] = '{mosi: 8'h81, tx: 8'h7E, exp_rx: 8'h81, exp_miso: 8'h7E};

    nreset = 1'b0; sclk = 1'b0; di = 1'b0; ncs = 1'b1; tx_data = 8'h00;
    clks(3);
    check("rst_miso", miso, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_strobes", {rx_valid, tx_taken, frame_start, frame_end}, 4'b0000);
    check("rst_byte_index", byte_index, '0);
    check("rst_busy", busy, 1'b0);
    nreset = 1'b1;
    clks(10);

    // Idle: sclk toggling with ncs high keeps MISO high and produces no strobes.
    fs0 = cnt_fs; tt0 = cnt_tt;
    for (int i = 0; i < 6; i++) begin
      di = i[0];
      sclk = ~sclk;
      clks(H);
      check("idle_miso", miso, 1'b1);
    end
    sclk = 1'b0;
    clks(H);
    check("idle_no_strobe", (cnt_fs - fs0) + (cnt_tt - tt0) + cnt_rv + cnt_fe, 0);

    // Table: single-byte frames.
    for (int v = 0; v < 4; v++) begin
      fs0 = cnt_fs; fe0 = cnt_fe; tt0 = cnt_tt; rv0 = cnt_rv;
      tx_data = vecs[v].tx;
      frame_begin();
      check("single_start", cnt_fs - fs0, 1);
      check("single_busy", busy, 1'b1);
      expect_rx(vecs[v].exp_rx, '0);
      send_bits(vecs[v].mosi, 8, got);
      check("single_miso", got, vecs[v].exp_miso);
      frame_stop();
      check("single_rv", cnt_rv - rv0, 1);
      check("single_tt", cnt_tt - tt0, 2);
      check("single_end", cnt_fe - fe0, 1);
      check("single_idx_hold", byte_index, '0);
      check("single_idle_miso", miso, 1'b1);
      check("single_busy_end", busy, 1'b0);
    end

    // Three bytes with tx_data stepped on every tx_taken.
    tx_step_q = '{8'h20, 8'h30, 8'h40, 8'h50};
    tx_data = 8'h10;
    tx_step_en = 1'b1;
    tt0 = cnt_tt; rv0 = cnt_rv;
    frame_begin();
    for (int b = 0; b < 3; b++) begin
      logic [7:0] exp_tx;
      expect_rx(8'(b + 1), IDX_W'(b));
      send_bits(8'(b + 1), 8, got);
      exp_tx = 8'((b + 1) * 16);
      check("multi_miso", got, exp_tx);
    end
    frame_stop();
    tx_step_en = 1'b0;
    check("multi_rv", cnt_rv - rv0, 3);
    check("multi_tt", cnt_tt - tt0, 4);

    // Abort after 5 sclk periods: no byte, frame_end, MISO back high promptly.
    tx_data = 8'h00;
    fe0 = cnt_fe; rv0 = cnt_rv;
    frame_begin();
    send_bits(8'hFF, 5, got);
    check("abort_miso_low", miso, 1'b0);
    ncs = 1'b1;
    clks(SYNC_STAGES + 2);
    check("abort_miso_high", miso, 1'b1);
    clks(8);
    check("abort_end", cnt_fe - fe0, 1);
    check("abort_no_rv", cnt_rv - rv0, 0);
    tx_data = 8'hC3;
    frame_begin();
    expect_rx(8'h5A, '0);
    send_bits(8'h5A, 8, got);
    check("after_abort_miso", got, 8'hC3);
    frame_stop();

    // Reset pulsed mid-frame with sclk active: no partial frame afterwards.
    tx_data = 8'h00;
    frame_begin();
    send_bits(8'h66, 3, got);
    nreset = 1'b0;
    clks(1);
    check("midrst_outputs", {miso, rx_valid, tx_taken, frame_start, frame_end, busy}, 6'b100000);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_idx", byte_index, '0);
    nreset = 1'b1;
    fs0 = cnt_fs; rv0 = cnt_rv; tt0 = cnt_tt;
    send_bits(8'h00, 8, got);
    check("midrst_miso_idle", got, 8'hFF);
    check("midrst_no_activity", (cnt_fs - fs0) + (cnt_rv - rv0) + (cnt_tt - tt0), 0);
    ncs = 1'b1;
    clks(8);
    check("midrst_still_no_start", cnt_fs - fs0, 0);
    tx_data = 8'h96;
    frame_begin();
    check("midrst_new_start", cnt_fs - fs0, 1);
    expect_rx(8'h3C, '0);
    send_bits(8'h3C, 8, got);
    check("midrst_new_miso", got, 8'h96);
    frame_stop();

    // Coincident end: ncs rise lands together with the 8th sclk rise.
    tx_data = 8'h55;
    cc0 = cnt_coinc; fe0 = cnt_fe; rv0 = cnt_rv;
    frame_begin();
    expect_rx(8'hE7, '0);
    send_bits(8'hE7, 7, got);
    di = 1'b1;
    clks(H);
    got[0] = miso;
    sclk = 1'b1;
    ncs  = 1'b1;
    clks(H);
    sclk = 1'b0;
    clks(8);
    check("coinc_miso", got, 8'h55);
    check("coinc_same_cycle", cnt_coinc - cc0, 1);
    check("coinc_end", cnt_fe - fe0, 1);
    check("coinc_rv", cnt_rv - rv0, 1);
    check("coinc_idle_miso", miso, 1'b1);

    check("rx_queue_drained", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
